// File: rtl/float_mantissa_multiplier.sv
// -----------------------------------------------------------------------------
// float_mantissa_multiplier
//
// Sequential radix-2 shift-add multiplier for unsigned N-bit significands
// (hidden bit included). Produces the exact 2N-bit product consumed by
// float_normalizer. Operands enter through a valid/ready handshake, the
// product leaves through another one, and the latency is always N edges
// from acceptance to y_valid, independent of the operand values.
//
// Ports
//   clock    in   1    rising-edge clock
//   reset    in   1    synchronous reset, active-high
//   a_valid  in   1    A/B operand pair is valid
//   a_ready  out  1    block can accept operands (IDLE only)
//   A        in   N    multiplicand, unsigned
//   B        in   N    multiplier, unsigned
//   y_valid  out  1    Y holds a finished product (DONE only)
//   y_ready  in   1    consumer accepts Y
//   Y        out  2N   registered product A*B
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for operands, a_ready=1
// S_BUSY  | one shift-add iteration per cycle, N iterations in total
// S_DONE  | product presented, y_valid=1, held until y_ready
// -----------------------------------------------------------------------------
module float_mantissa_multiplier #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [2*N-1:0] Y
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam int PW    = 2 * N;

  if (N < 2) begin : g_bad_n
    $error("float_mantissa_multiplier: N must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [N-1:0]     mcand_q,  mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [PW-1:0]    y_q,      y_d;

  logic [PW-1:0]    addend;
  logic             last_iter;

  // Multiplicand weighted by the current iteration index. The counter never
  // exceeds N-1 while BUSY, so the shifted value always fits in 2N bits.
  assign addend    = {{N{1'b0}}, mcand_q} << cnt_q;
  assign last_iter = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;

    case (state_q)
      S_IDLE: begin
        if (a_valid) begin
          mcand_d  = A;
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + addend;
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The final iteration's partial product is folded into Y on the
        // same edge that enters DONE, so latency stays exactly N edges.
        if (last_iter) begin
          y_d     = acc_d;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (y_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  // Handshake flags are pure functions of state, never of a_valid/y_ready.
  assign a_ready = (state_q == S_IDLE);
  assign y_valid = (state_q == S_DONE);
  assign Y       = y_q;

endmodule

// File: tb/tb_float_mantissa_multiplier.sv
module tb_float_mantissa_multiplier;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         y_valid;
  logic         y_ready;
  logic [2*N-1:0] Y;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  float_mantissa_multiplier #(.N(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .A       (A),
    .B       (B),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .Y       (Y)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Waits (bounded) for a_ready, then presents A/B for one accepting edge.
  // Returns with time at 1 unit after the accepting edge.
  task automatic accept_op(input logic [N-1:0] a, input logic [N-1:0] b,
                           output bit ok);
    int guard;
    guard = 0;
    while (!a_ready && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    ok = a_ready;
    A = a;
    B = b;
    a_valid = 1'b1;
    @(posedge clock); #1;
    a_valid = 1'b0;
  endtask

  // Counts edges after acceptance until y_valid is seen (bounded at 40).
  task automatic wait_y_valid(output int edges);
    edges = 0;
    do begin
      @(posedge clock); #1;
      edges++;
    end while (!y_valid && edges < 40);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    tests_run++;
    if (a_ready !== 1'b1 || y_valid !== 1'b0 || Y !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state: a_ready=%b y_valid=%b Y=%0d, want 1 0 0", a_ready, y_valid, Y);
    end
  endtask

  task automatic test_basic;
    bit ok;
    int edges;
    int msb;
    y_ready = 1'b1;
    accept_op(4'd13, 4'd11, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL basic_accept: a_ready=0, want 1"); end
    wait_y_valid(edges);
    tests_run++;
    if (edges !== N) begin tests_failed++; $display("FAIL basic_latency: edges=%0d, want %0d", edges, N); end
    tests_run++;
    if (Y !== 8'd143) begin tests_failed++; $display("FAIL basic_product: Y=%0d, want 143", Y); end
    msb = -1;
    for (int i = 0; i < 2*N; i++) if (Y[i]) msb = i;
    tests_run++;
    if (msb !== 7) begin tests_failed++; $display("FAIL basic_msb_pos: msb=%0d, want 7", msb); end
    tests_run++;
    if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL basic_ready_excl: a_ready=%b, want 0", a_ready); end
    @(posedge clock); #1;
    tests_run++;
    if (a_ready !== 1'b1 || y_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_return_idle: a_ready=%b y_valid=%b, want 1 0", a_ready, y_valid);
    end
  endtask

  task automatic test_extremes;
    logic [N-1:0] va [3] = '{4'd15, 4'd0, 4'd1};
    logic [N-1:0] vb [3] = '{4'd15, 4'd9, 4'd1};
    logic [7:0]   vy [3] = '{8'd225, 8'd0, 8'd1};
    bit ok;
    int edges;
    y_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept_op(va[i], vb[i], ok);
      wait_y_valid(edges);
      tests_run++;
      if (edges !== N) begin tests_failed++; $display("FAIL extreme_latency[%0d]: edges=%0d, want %0d", i, edges, N); end
      tests_run++;
      if (Y !== vy[i]) begin tests_failed++; $display("FAIL extreme_product[%0d]: Y=%0d, want %0d", i, Y, vy[i]); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int edges;
    y_ready = 1'b0;
    accept_op(4'd6, 4'd7, ok);
    wait_y_valid(edges);
    tests_run++;
    if (edges !== N) begin tests_failed++; $display("FAIL bp_latency: edges=%0d, want %0d", edges, N); end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin A = 4'd3; B = 4'd3; a_valid = 1'b1; end
      else        a_valid = 1'b0;
      tests_run++;
      if (Y !== 8'd42 || y_valid !== 1'b1 || a_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: Y=%0d y_valid=%b a_ready=%b, want 42 1 0", c, Y, y_valid, a_ready);
      end
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    y_ready = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (a_ready !== 1'b1 || y_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: a_ready=%b y_valid=%b, want 1 0", a_ready, y_valid);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      tests_run++;
      if (y_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_ignored_pulse[%0d]: y_valid=%b, want 0", c, y_valid); end
    end
  endtask

  task automatic test_isolation;
    bit ok;
    y_ready = 1'b0;
    accept_op(4'd5, 4'd9, ok);
    for (int e = 1; e <= N; e++) begin
      A = 4'($urandom);
      B = 4'($urandom);
      a_valid = 1'($urandom);
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    tests_run++;
    if (y_valid !== 1'b1 || Y !== 8'd45) begin
      tests_failed++;
      $display("FAIL isolation: y_valid=%b Y=%0d, want 1 45", y_valid, Y);
    end
    y_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_op;
    bit ok;
    int edges;
    y_ready = 1'b1;
    accept_op(4'd12, 4'd10, ok);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests_run++;
    if (a_ready !== 1'b1 || y_valid !== 1'b0 || Y !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_state: a_ready=%b y_valid=%b Y=%0d, want 1 0 0", a_ready, y_valid, Y);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      tests_run++;
      if (y_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_spurious[%0d]: y_valid=%b, want 0", c, y_valid); end
    end
    accept_op(4'd2, 4'd3, ok);
    wait_y_valid(edges);
    tests_run++;
    if (edges !== N || Y !== 8'd6) begin
      tests_failed++;
      $display("FAIL reset_mid_fresh: edges=%0d Y=%0d, want %0d 6", edges, Y, N);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_vs_accept;
    A = 4'd7;
    B = 4'd7;
    a_valid = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    a_valid = 1'b0;
    tests_run++;
    if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wins: a_ready=%b, want 1", a_ready); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      tests_run++;
      if (y_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wins_no_op[%0d]: y_valid=%b, want 0", c, y_valid); end
    end
  endtask

  task automatic test_back_to_back;
    int prev_acc;
    int acc_cyc;
    int guard;
    int expected;
    y_ready = 1'b1;
    prev_acc = 0;
    for (int idx = 0; idx < 256; idx++) begin
      A = 4'(idx >> 4);
      B = 4'(idx);
      expected = (idx >> 4) * (idx & 15);
      a_valid = 1'b1;
      guard = 0;
      while (!a_ready && guard < 20) begin
        @(posedge clock); #1;
        guard++;
      end
      @(posedge clock); #1;
      acc_cyc = cyc;
      a_valid = 1'b0;
      if (idx > 0) begin
        tests_run++;
        if (acc_cyc - prev_acc !== N + 2) begin
          tests_failed++;
          $display("FAIL stream_spacing[%0d]: spacing=%0d, want %0d", idx, acc_cyc - prev_acc, N + 2);
        end
      end
      prev_acc = acc_cyc;
      guard = 0;
      do begin
        @(posedge clock); #1;
        guard++;
      end while (!y_valid && guard < 40);
      tests_run++;
      if (y_valid !== 1'b1 || Y !== 8'(expected)) begin
        tests_failed++;
        $display("FAIL stream_product[%0d]: y_valid=%b Y=%0d, want 1 %0d", idx, y_valid, Y, expected);
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    reset   = 1'b1;
    a_valid = 1'b0;
    y_ready = 1'b0;
    A       = '0;
    B       = '0;
    #1;
    test_reset;
    test_basic;
    test_extremes;
    test_backpressure;
    test_isolation;
    test_reset_mid_op;
    test_reset_vs_accept;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/float_mantissa_multiplier.md
# float_mantissa_multiplier

Sequential radix-2 shift-add multiplier for unsigned N-bit significands. It produces the exact 2N-bit product that feeds `float_normalizer`, whose `A` input is 2N bits wide. Operands and results move through valid/ready handshakes, so the FPU control can stall either side. Latency is fixed and does not depend on the data.

## Interface
- `N`, default 4: significand width in bits, including the hidden bit. Must be ≥ 2.

- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous reset, active-high
- `a_valid`  in  1  operand pair `A`/`B` is valid
- `a_ready`  out  1  block is able to accept operands
- `A`  in  N  multiplicand, unsigned
- `B`  in  N  multiplier, unsigned
- `y_valid`  out  1  `Y` holds a finished product
- `y_ready`  in  1  consumer accepts `Y`
- `Y`  out  2N  product A·B, unsigned and exact; goes directly to `float_normalizer.A`

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - `a_ready`=1.
  - On `a_valid && a_ready`: latch `A` into the multiplicand register, latch `B` into the shift register, clear the accumulator and iteration counter, then go to BUSY.
- BUSY:
  - `a_ready`=0.
  - Each cycle: if the multiplier LSB is 1, accumulator += multiplicand·2^k (k = iteration index). Then shift the multiplier right by 1 and increment the counter.
  - After exactly N iterations, write the accumulator to `Y` and go to DONE.
  - The counter is $clog2(N)+1 bits and wraps only through reset or reload.
- DONE:
  - `y_valid`=1 and `Y` is held stable.
  - On `y_valid && y_ready`: go to IDLE and drop `y_valid`.
  - There is no same-cycle bypass: `a_ready` returns to 1 one cycle after the output handshake.
- Arithmetic:
  - The accumulator is 2N bits. (2^N−1)^2 < 2^(2N), so the product never overflows.
  - All-ones × all-ones must give exactly (2^N−1)^2.
- Input isolation: `A`, `B` and `a_valid` are ignored outside IDLE. Changing them during BUSY or DONE has no effect.
- Zero operands take the full N iterations and give `Y`=0. There is no early termination.
- Reset:
  - `reset` overrides everything in the same edge. State goes to IDLE, and the operation in flight is discarded without ever asserting `y_valid`.
  - Reset values: `a_ready`=1, `y_valid`=0, `Y`=0. Internal registers are 0.
- `Y` is registered and changes only on the edge that enters DONE or on reset.

## Timing
- Edge numbering: the accepting edge is edge 0 (IDLE→BUSY). Iterations happen on edges 1..N. Edge N enters DONE.
- `y_valid` is 1 starting in the cycle after edge N, so latency is N edges from acceptance.
- With `y_ready` held at 1:
  - the output handshake is on edge N+1;
  - `a_ready`=1 after edge N+1;
  - the earliest next acceptance is edge N+2.
  - Maximum throughput is therefore one product every N+2 cycles.
- Backpressure: while `y_ready`=0, DONE holds indefinitely with `y_valid`=1, `Y` constant and `a_ready`=0.
- `a_ready` and `y_valid` are never both 1.
- `a_ready` depends only on state. It must not combinationally depend on `a_valid` or `y_ready`.
- Reset asserted on the same edge as an `a_valid` handshake: reset wins, and the operands are not captured.

## Test plan
- **Basic product, N=4.** After reset, check `a_ready`=1, `y_valid`=0, `Y`=0. Drive A=13, B=11, `a_valid`=1 for one cycle.
  - Required: `y_valid` rises exactly 4 edges after acceptance with `Y`=143 (0x8F).
  - Feed that `Y` to `float_normalizer`: msb_pos=7.
- **Extremes.**
  - A=15, B=15 → `Y`=225.
  - A=0, B=9 → `Y`=0, still after 4 edges.
  - A=1, B=1 → `Y`=1.
- **Backpressure.** A=6, B=7 with `y_ready`=0 for 10 cycles.
  - Required: `Y`=42 stays stable, `y_valid` stays 1, `a_ready` stays 0.
  - A new `a_valid` pulse (A=3, B=3) during this window is ignored.
  - Raise `y_ready`: handshake occurs, and `a_ready`=1 one cycle later.
- **Input isolation.** Accept A=5, B=9, then toggle A/B randomly during BUSY.
  - Required: `Y`=45.
- **Reset mid-operation.** Accept A=12, B=10, then assert `reset` on iteration edge 2.
  - Required: next cycle shows `a_ready`=1, `y_valid`=0, `Y`=0, and no spurious `y_valid` afterwards.
  - A fresh A=2, B=3 then yields `Y`=6.
- **Exhaustive streaming.** Cover all 256 operand pairs for N=4 back-to-back with `y_ready`=1.
  - Required: each `Y` equals A·B, and acceptances are spaced exactly N+2=6 cycles apart.
